// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The state encoding is visible to any checker that imports this package.
package loader_pkg;

  localparam int DATA_W_DEFAULT = 24;
  localparam int BYTES_PER_WORD = DATA_W_DEFAULT / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    WORD   = 3'd3,
    WRITE  = 3'd4,
    CKSUM  = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_e;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a stream of bytes into one instruction word, MSB first.
// last_byte flags that the next accepted byte completes the word.
module byte_packer
  import loader_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word_out,
  output logic              last_byte
);

  localparam int BPW   = bytes_per_word(DATA_W);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  assign last_byte = (idx_q == IDX_W'(BPW - 1));
  assign word_out  = word_q;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clr) begin
      word_d = '0;
      idx_d  = '0;
    end else if (shift_en) begin
      // Shifting left keeps the first received byte in the MSB position.
      word_d = (word_q << 8) | DATA_W'(byte_in);
      idx_d  = last_byte ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Receives a length-prefixed, XOR-checksummed byte frame, writes it into
// instruction memory word by word, and releases the CPU only on a good image.
module program_loader
  import loader_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // Handshake: a byte transfers on a cycle where in_valid && in_ready;
  // in_ready is decoded from the state alone and never looks at in_valid.

  localparam logic [16:0] DEPTH_V = 17'(DEPTH);

  state_e            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       idx_q, idx_d;
  logic [7:0]        xor_q, xor_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              accept;
  logic              pk_clr;
  logic              pk_shift;
  logic [DATA_W-1:0] pk_word;
  logic              pk_last;
  logic [15:0]       n_next;
  logic [15:0]       idx_inc;

  byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .shift_en (pk_shift),
    .byte_in  (in_data),
    .word_out (pk_word),
    .last_byte(pk_last)
  );

  assign in_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                    (state_q == WORD)   || (state_q == CKSUM);
  assign accept   = in_valid && in_ready;
  assign n_next   = {n_q[15:8], in_data};
  assign idx_inc  = idx_q + 16'd1;

  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = imem_we ? idx_q[ADDR_W-1:0] : addr_q;
  assign imem_wdata = imem_we ? pk_word : wdata_q;
  assign cpu_hold   = (state_q != DONE);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    xor_d    = xor_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pk_clr   = 1'b0;
    pk_shift = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (load_start) begin
          state_d = LEN_HI;
          xor_d   = '0;
          idx_d   = '0;
        end
      end
      LEN_HI: begin
        if (accept) begin
          n_d     = {in_data, n_q[7:0]};
          xor_d   = xor_q ^ in_data;
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          n_d   = n_next;
          xor_d = xor_q ^ in_data;
          // Oversize is rejected here so imem_addr can never wrap.
          if ({1'b0, n_next} > DEPTH_V) begin
            state_d = ERR;
          end else if (n_next == 16'd0) begin
            state_d = CKSUM;
          end else begin
            state_d = WORD;
            pk_clr  = 1'b1;
          end
        end
      end
      WORD: begin
        if (accept) begin
          pk_shift = 1'b1;
          xor_d    = xor_q ^ in_data;
          if (pk_last) state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = idx_q[ADDR_W-1:0];
        wdata_d = pk_word;
        idx_d   = idx_inc;
        state_d = (idx_inc == n_q) ? CKSUM : WORD;
      end
      CKSUM: begin
        if (accept) begin
          state_d = (in_data == xor_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      xor_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Byte-stream writer that fills the CPU's 24-bit instruction memory and holds the CPU in reset until a complete, checksum-verified image has been written. It feeds the fetch path from the write side: it packs bytes into instructions and drives sequential instruction-memory write addresses. It sits between a host byte source (UART or bench) and instr_memory's write port. It gates the CPU through cpu_hold.

Parameters:
DATA_W, 24, instruction word width; must be a multiple of 8.
ADDR_W, 10, instruction-memory write address width.
DEPTH, 1024, number of writable instruction words; must be at most 2**ADDR_W.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
load_start  input  1  single-cycle pulse that begins a load
in_valid  input  1  byte available on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts in_data this cycle
imem_we  output  1  instruction-memory write enable
imem_addr  output  ADDR_W  write address
imem_wdata  output  DATA_W  write data
cpu_hold  output  1  drives the CPU's rst while high
done  output  1  image loaded and verified; level signal
error  output  1  load failed; level signal

Behaviour:
- Frame format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N words of DATA_W/8 bytes each, MSB first.
  - CKSUM: one byte equal to the XOR of every preceding frame byte, including the length bytes.
- Byte transfer: a byte moves only on a cycle where in_valid and in_ready are both high. in_ready is combinational from state only; it never depends on in_valid.
- Reset values (rst high at a clk edge): state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 1, done 0, error 0. The byte counter, word counter and running XOR are all cleared.
- States:
  - IDLE: in_ready 0. load_start moves to LEN_HI and clears the running XOR.
  - LEN_HI, LEN_LO: in_ready 1; capture the length bytes into N.
    - After LEN_LO: if N > DEPTH, go to ERR.
    - Else if N == 0, go to CKSUM.
    - Else go to WORD.
  - WORD: in_ready 1; shift bytes into the packer. On acceptance of the last byte of a word, go to WRITE.
  - WRITE: exactly one cycle; in_ready 0, imem_we 1, imem_wdata = packed word, imem_addr = word index.
    - Then increment the word index.
    - Go to CKSUM if index+1 == N, else to WORD.
  - CKSUM: in_ready 1. On byte acceptance, go to DONE if the byte equals the running XOR, else to ERR.
  - DONE: done 1, cpu_hold 0, in_ready 0.
  - ERR: error 1, cpu_hold 1, in_ready 0.
- Write timing: imem_we is asserted in the cycle immediately after the final byte of a word is accepted. Minimum spacing is (DATA_W/8)+1 cycles per word.
- imem_addr starts at 0 for every load and increments by 1 per word. It never wraps, because N > DEPTH is rejected before any write.
- imem_we is low in every state except WRITE. imem_addr and imem_wdata hold their last values outside WRITE.
- cpu_hold is 1 in every state except DONE.
- load_start:
  - In DONE or ERR: restart at LEN_HI. cpu_hold rises and done/error clear on the next cycle.
  - In any other state: ignored.
- Boundary conditions:
  - in_valid low in a receiving state: hold state indefinitely; no timeout.
  - rst mid-load: return to reset values next cycle. Memory words already written stay as written.
  - rst and load_start in the same cycle: rst wins.
  - Partial image then ERR: written words remain in memory; the CPU stays held.

Decomposition:
- loader_pkg: state enum (IDLE, LEN_HI, LEN_LO, WORD, WRITE, CKSUM, DONE, ERR) and the BYTES_PER_WORD = DATA_W/8 constant.
- Sub-module byte_packer: shift register with a byte index.
  - Inputs: shift_en, clr, byte_in.
  - Outputs: word_out, last_byte (asserted when the index is BYTES_PER_WORD-1).
  - Cleared on rst and on every entry to WORD from LEN_LO.

Test Plan:
- Reset: rst high 2 cycles -> cpu_hold=1, done=0, error=0, imem_we=0, in_ready=0, imem_addr=0.
- Single word: load_start, then bytes 00 01 12 34 56 71 with in_valid held high -> one imem_we pulse with addr 0, data 0x123456, the cycle after byte 56; then done=1, cpu_hold=0.
- Two words with gaps: bytes 00 02 AB CD EF 00 00 01 8A, in_valid dropped for 3 cycles mid-word -> writes addr0=0xABCDEF and addr1=0x000001; done=1.
- Empty image and bad checksum:
  - Bytes 00 00 00 -> done=1 with no imem_we.
  - Repeat with checksum 0x70 instead of 0x71 in the single-word frame -> error=1, cpu_hold=1, address 0 still written.
- Oversize: bytes 04 01 (N=1025 > DEPTH 1024) -> ERR after the second byte; no imem_we; in_ready=0.
- Control corner cases:
  - rst asserted after 4 bytes of the two-word frame -> reset values next cycle.
  - load_start pulsed during WORD -> ignored.
  - load_start in DONE -> cpu_hold=1 and done=0 the next cycle.
